// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the UART instruction-memory boot loader:
//   SYNC_BYTE      - first byte of every program frame
//   state_t        - loader FSM state encoding
//   status_t       - registered status outputs that belong to one state
//   clks_per_bit() - clock cycles per UART bit (integer division)
//   decode_status()- status outputs that go with a given state
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic cpu_reset;
        logic busy;
        logic done;
        logic error;
    } status_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // The core only runs once a verified image is in place, so every state
    // except DONE keeps it in reset.
    function automatic status_t decode_status(input state_t s);
        status_t st;
        st.cpu_reset = 1'b1;
        st.busy      = 1'b0;
        st.done      = 1'b0;
        st.error     = 1'b0;
        case (s)
            LEN_HI, LEN_LO, DATA, CSUM: st.busy = 1'b1;
            DONE: begin
                st.cpu_reset = 1'b0;
                st.done      = 1'b1;
            end
            ERROR:   st.error = 1'b1;
            default: st.busy  = 1'b0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Instruction-memory write port driven by the boot loader.
//   we    - one-cycle write strobe
//   addr  - word address (ADDR_W bits)
//   wdata - 32-bit word
// master: the loader (drives), slave: the instruction memory (receives).
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input  we, input  addr, input  wdata);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// uart_rx_8n1
// 8N1 UART receiver, LSB first, with a 2-flop input synchronizer.
//   clk, reset_n - clock and asynchronous active-low reset
//   rx           - raw serial line, idle high
//   rx_byte      - last correctly framed byte
//   byte_valid   - 1-cycle pulse when rx_byte is updated (stop-bit mid-sample)
//   frame_err    - 1-cycle pulse when the stop bit was sampled low
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    logic [2:0]       sync;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_s;
    logic             fall;

    // sync[1] is the synchronized line, sync[2] its previous value; the
    // extra flop lets a start bit be recognised as a falling edge so that
    // a line held low (break) does not retrigger.
    assign rx_s = sync[1];
    assign fall = sync[2] & ~sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], rx};
        end
    end

    // Bit timer: half a bit to reach the start-bit centre, then whole bits
    // to land in the centre of each data bit and the stop bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    if (fall) rx_state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == FULL_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == FULL_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            rx_byte    <= shift_reg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader
// UART boot loader: receives a framed program image
//   A5, N_hi, N_lo, N*4 data bytes (big-endian words), XOR checksum of data
// writes it word by word into instruction memory and keeps the core in
// reset until a verified image is loaded.
//   clk, reset_n - clock and asynchronous active-low reset
//   uart_rx      - serial input, idle high
//   imem         - instruction-memory write port (master side)
//   cpu_reset    - active-high reset to the core, low only in DONE
//   load_busy    - a frame is being received
//   load_done    - last frame loaded and verified
//   load_error   - last frame rejected
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_rx,
    imem_loader_if.master        imem,
    output logic                 cpu_reset,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 load_error
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state;
    status_t           status;
    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              frame_err;
    logic [7:0]        len_hi;
    logic [15:0]       len_words;
    logic [ADDR_W:0]   addr_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       word_asm;
    logic [7:0]        csum;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_next;
    logic [ADDR_W:0]   addr_next;
    logic [15:0]       len_next;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (uart_rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Only the three previous bytes of a word need to be held; the fourth
    // arrives with the write.
    assign word_next = {word_asm, rx_byte};
    assign addr_next = addr_cnt + 1'b1;
    assign len_next  = {len_hi, rx_byte};

    // Frame FSM with word assembler and checksum. Status outputs are
    // registered together with the state so they change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            status    <= decode_status(IDLE);
            len_hi    <= '0;
            len_words <= '0;
            addr_cnt  <= '0;
            byte_idx  <= '0;
            word_asm  <= '0;
            csum      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (frame_err) begin
                if (state inside {LEN_HI, LEN_LO, DATA, CSUM}) begin
                    state  <= ERROR;
                    status <= decode_status(ERROR);
                end
            end else if (byte_valid) begin
                unique case (state)
                    IDLE, DONE, ERROR: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state  <= LEN_HI;
                            status <= decode_status(LEN_HI);
                        end
                    end
                    LEN_HI: begin
                        len_hi <= rx_byte;
                        state  <= LEN_LO;
                        status <= decode_status(LEN_LO);
                    end
                    LEN_LO: begin
                        // The address counter has one spare bit, so exactly
                        // 2^ADDR_W words is still a legal image.
                        if (len_next == 16'd0 || {1'b0, len_next} > MAX_WORDS) begin
                            state  <= ERROR;
                            status <= decode_status(ERROR);
                        end else begin
                            len_words <= len_next;
                            addr_cnt  <= '0;
                            byte_idx  <= '0;
                            csum      <= '0;
                            state     <= DATA;
                            status    <= decode_status(DATA);
                        end
                    end
                    DATA: begin
                        word_asm <= word_next[23:0];
                        csum     <= csum ^ rx_byte;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            we_q     <= 1'b1;
                            addr_q   <= addr_cnt[ADDR_W-1:0];
                            wdata_q  <= word_next;
                            addr_cnt <= addr_next;
                            if (16'(addr_next) == len_words) begin
                                state  <= CSUM;
                                status <= decode_status(CSUM);
                            end
                        end
                    end
                    CSUM: begin
                        if (rx_byte == csum) begin
                            state  <= DONE;
                            status <= decode_status(DONE);
                        end else begin
                            state  <= ERROR;
                            status <= decode_status(ERROR);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        status <= decode_status(IDLE);
                    end
                endcase
            end
        end
    end

    assign imem.we    = we_q;
    assign imem.addr  = addr_q;
    assign imem.wdata = wdata_q;
    assign cpu_reset  = status.cpu_reset;
    assign load_busy  = status.busy;
    assign load_done  = status.done;
    assign load_error = status.error;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Table-driven bench for imem_loader at 16 clocks per UART bit, plus
// hand-written sequences for asynchronous reset mid-frame, false start
// rejection and restart from DONE / ERROR.
module tb_imem_loader;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 16;
    localparam logic [7:0] NO_BAD = 8'hFF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic uart_rx = 1'b1;
    logic cpu_reset, load_busy, load_done, load_error;

    imem_loader_if #(.ADDR_W(8)) imem_bus ();

    imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .imem       (imem_bus),
        .cpu_reset  (cpu_reset),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // One record per frame: bytes left-aligned in frame (byte 0 in the top
    // eight bits), index of a byte sent with a bad stop bit, and expected
    // final status plus the words that must have been written.
    typedef struct packed {
        logic [127:0]     frame;
        logic [7:0]       nbytes;
        logic [7:0]       bad_stop;
        logic             exp_done;
        logic             exp_error;
        logic             exp_cpu_reset;
        logic             exp_busy;
        logic [7:0]       exp_writes;
        logic [1:0][31:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    int tests_run = 0;
    int tests_failed = 0;
    int bv_count = 0;
    int we_long = 0;
    logic we_prev = 1'b0;
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Write log and strobe-width monitor, sampled away from the clock edge.
    always @(negedge clk) begin
        if (imem_bus.we) begin
            wr_addr_q.push_back(imem_bus.addr);
            wr_data_q.push_back(imem_bus.wdata);
            if (we_prev) we_long++;
        end
        we_prev = imem_bus.we;
        if (dut.byte_valid) bv_count++;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int v, input int count);
        for (int k = 0; k < count; k++) begin
            send_byte(vecs[v].frame[127 - 8 * k -: 8], (k[7:0] == vecs[v].bad_stop) ? 1'b0 : 1'b1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Waits for the A5 byte_valid, checks the old status is still present in
    // that cycle and the restarted status one cycle later.
    task automatic watch_restart(input bit from_done);
        int n = 0;
        while (!dut.byte_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_output("restart_byte_seen", 32'(n < 400), 32'd1);
        if (n < 400) begin
            if (from_done) check_output("restart_pre_cpu_reset", cpu_reset, 1'b0);
            else           check_output("restart_pre_error", load_error, 1'b1);
            @(negedge clk);
            if (from_done) check_output("restart_cpu_reset", cpu_reset, 1'b1);
            else           check_output("restart_error_cleared", load_error, 1'b0);
            check_output("restart_busy", load_busy, 1'b1);
        end
    endtask

    initial begin
        int base;
        int got;
        int bv_before;

        vecs[0] = '{frame: {104'h00A5000220010005002208202E, 24'h0}, nbytes: 8'd13, bad_stop: NO_BAD,
                    exp_done: 1'b1, exp_error: 1'b0, exp_cpu_reset: 1'b0, exp_busy: 1'b0,
                    exp_writes: 8'd2, exp_word: {32'h00220820, 32'h20010005}};
        vecs[1] = '{frame: {96'hA5000220010005002208202F, 32'h0}, nbytes: 8'd12, bad_stop: NO_BAD,
                    exp_done: 1'b0, exp_error: 1'b1, exp_cpu_reset: 1'b1, exp_busy: 1'b0,
                    exp_writes: 8'd2, exp_word: {32'h00220820, 32'h20010005}};
        vecs[2] = '{frame: {24'hA50000, 104'h0}, nbytes: 8'd3, bad_stop: NO_BAD,
                    exp_done: 1'b0, exp_error: 1'b1, exp_cpu_reset: 1'b1, exp_busy: 1'b0,
                    exp_writes: 8'd0, exp_word: 64'h0};
        vecs[3] = '{frame: {48'hA50002112233, 80'h0}, nbytes: 8'd6, bad_stop: 8'd5,
                    exp_done: 1'b0, exp_error: 1'b1, exp_cpu_reset: 1'b1, exp_busy: 1'b0,
                    exp_writes: 8'd0, exp_word: 64'h0};
        vecs[4] = '{frame: {24'hA50101, 104'h0}, nbytes: 8'd3, bad_stop: NO_BAD,
                    exp_done: 1'b0, exp_error: 1'b1, exp_cpu_reset: 1'b1, exp_busy: 1'b0,
                    exp_writes: 8'd0, exp_word: 64'h0};
        vecs[5] = '{frame: {64'hA50001DEADBEEF22, 64'h0}, nbytes: 8'd8, bad_stop: NO_BAD,
                    exp_done: 1'b1, exp_error: 1'b0, exp_cpu_reset: 1'b0, exp_busy: 1'b0,
                    exp_writes: 8'd1, exp_word: {32'h0, 32'hDEADBEEF}};
        vecs[6] = '{frame: {24'hA50100, 104'h0}, nbytes: 8'd3, bad_stop: NO_BAD,
                    exp_done: 1'b0, exp_error: 1'b0, exp_cpu_reset: 1'b1, exp_busy: 1'b1,
                    exp_writes: 8'd0, exp_word: 64'h0};

        // Reset values
        repeat (4) @(negedge clk);
        check_output("rst_cpu_reset", cpu_reset, 1'b1);
        check_output("rst_busy", load_busy, 1'b0);
        check_output("rst_done", load_done, 1'b0);
        check_output("rst_error", load_error, 1'b0);
        check_output("rst_we", imem_bus.we, 1'b0);
        check_output("rst_addr", imem_bus.addr, 8'h00);
        check_output("rst_wdata", imem_bus.wdata, 32'h0);
        reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            do_reset();
            base = wr_addr_q.size();
            we_long = 0;
            apply_stimulus(v, int'(vecs[v].nbytes));
            got = wr_addr_q.size() - base;
            check_output($sformatf("v%0d_done", v), load_done, vecs[v].exp_done);
            check_output($sformatf("v%0d_error", v), load_error, vecs[v].exp_error);
            check_output($sformatf("v%0d_cpu_reset", v), cpu_reset, vecs[v].exp_cpu_reset);
            check_output($sformatf("v%0d_busy", v), load_busy, vecs[v].exp_busy);
            check_output($sformatf("v%0d_writes", v), 32'(got), 32'(vecs[v].exp_writes));
            check_output($sformatf("v%0d_we_width", v), 32'(we_long), 32'd0);
            for (int k = 0; k < 2; k++) begin
                if (k < int'(vecs[v].exp_writes) && base + k < wr_addr_q.size()) begin
                    check_output($sformatf("v%0d_addr%0d", v, k), 32'(wr_addr_q[base + k]), 32'(k));
                    check_output($sformatf("v%0d_data%0d", v, k), wr_data_q[base + k], vecs[v].exp_word[k]);
                end
            end
        end

        // Asynchronous reset after five data bytes, then a full resend
        do_reset();
        apply_stimulus(0, 9);
        check_output("midreset_busy_before", load_busy, 1'b1);
        check_output("midreset_wdata_before", imem_bus.wdata, 32'h20010005);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("midreset_busy", load_busy, 1'b0);
        check_output("midreset_cpu_reset", cpu_reset, 1'b1);
        check_output("midreset_wdata", imem_bus.wdata, 32'h0);
        check_output("midreset_addr", imem_bus.addr, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        base = wr_addr_q.size();
        apply_stimulus(0, 13);
        check_output("resend_writes", 32'(wr_addr_q.size() - base), 32'd2);
        if (wr_addr_q.size() - base >= 1) begin
            check_output("resend_addr0", 32'(wr_addr_q[base]), 32'd0);
            check_output("resend_data0", wr_data_q[base], 32'h20010005);
        end
        check_output("resend_done", load_done, 1'b1);

        // One-cycle glitch must not produce a byte
        bv_before = bv_count;
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        check_output("glitch_no_byte", 32'(bv_count - bv_before), 32'd0);
        check_output("glitch_still_done", load_done, 1'b1);

        // Restart from DONE
        fork
            send_byte(8'hA5, 1'b1);
            watch_restart(1'b1);
        join

        // Restart from ERROR
        do_reset();
        apply_stimulus(2, 3);
        fork
            send_byte(8'hA5, 1'b1);
            watch_restart(1'b0);
        join

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

UART boot loader that is the write side of the CPU's instruction memory: it receives a framed program image over a serial line and writes it word-by-word into instruction memory. While it loads, it holds the single-cycle core in reset, and it releases the core only after a verified image is in place. It sits between the board UART pin and the instruction memory write port, alongside the core's PC/fetch path, which only reads that memory.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: UART bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division, must be ≥ 8.
- `ADDR_W`, 8: instruction memory word-address width. Addresses are word-indexed, matching PC+1 stepping.

Ports:
- `clk` in 1: single clock, the PLL output that also clocks the core.
- `reset_n` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial input, idle high, asynchronous to `clk`.
- `imem_we` out 1: one-cycle write strobe.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: word data.
- `cpu_reset` out 1: active-high reset to the core, PC and register file.
- `load_busy` out 1: a frame is being received.
- `load_done` out 1: last frame was loaded and verified.
- `load_error` out 1: last frame was rejected.

## Operation
- Frame format: byte `0xA5`, then N_hi, then N_lo, then N×4 data bytes, then a checksum byte.
  - N is a 16-bit word count.
  - Each word is sent big-endian.
  - The checksum is the XOR of all data bytes only.
- `uart_rx` passes through a 2-flop synchronizer, then the 8N1 receiver, LSB first.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- **IDLE, DONE, ERROR:** a byte of `0xA5` goes to LEN_HI. Any other byte is ignored.
- **LEN_HI → LEN_LO:** latch N_hi.
- **LEN_LO:** latch N_lo.
  - N = 0 or N > 2^ADDR_W goes to ERROR.
  - Otherwise go to DATA with address = 0, byte index = 0, checksum = 0.
- **DATA:** shift each byte into a 32-bit assembler and XOR it into the checksum.
  - On the 4th byte, write the assembled word to the current address, then increment the address.
  - After word N-1 is written, go to CSUM.
- **CSUM:** if the received byte equals the checksum, go to DONE. Otherwise go to ERROR.
- **Framing error:** a stop bit sampled 0 in any state other than IDLE, DONE or ERROR goes to ERROR. The byte is discarded.
- **Output decode:**
  - `load_busy` is 1 in LEN_HI, LEN_LO, DATA and CSUM.
  - `load_done` is 1 only in DONE.
  - `load_error` is 1 only in ERROR.
  - `cpu_reset` is 0 only in DONE.
- A rejected or partial image leaves the written words in memory, but the core stays in reset.

## Timing
- **Reset values:** state IDLE, `cpu_reset`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_busy`=0, `load_done`=0, `load_error`=0. All counters are 0.
- **Reset mid-frame:** everything is cleared immediately (asynchronous), and the partial frame is abandoned. Reception resumes on the next start bit after `reset_n` rises.
- **Receiver start bit:** a falling edge starts a count of CLKS_PER_BIT/2.
  - If the line is high at the mid-bit sample, it is a false start and the receiver returns to idle with no byte.
- **Receiver data and stop bits:** the 8 data bits and the stop bit are sampled at CLKS_PER_BIT intervals. `byte_valid` pulses for 1 cycle at the stop-bit mid-sample.
- **Writes:** `imem_we` pulses for exactly 1 cycle, registered, on the cycle after the `byte_valid` of the 4th byte. `imem_addr` and `imem_wdata` are stable in that cycle and hold until the next write.
- **Completion:** the FSM moves to DONE or ERROR on the cycle after the checksum byte's `byte_valid`, and outputs update in that same cycle.
- **Restart from DONE:** a `0xA5` byte reasserts `cpu_reset` 1 cycle after its `byte_valid`.
- **Restart from ERROR:** a `0xA5` byte clears `load_error` 1 cycle after its `byte_valid`.
- The address counter is ADDR_W+1 bits wide, so it never wraps inside a valid frame.

## Structure
- Shared package holds the `SYNC_BYTE` (`0xA5`) constant, the FSM state encoding, and the `CLKS_PER_BIT` derivation.
- One sub-module, `uart_rx_8n1` (synchronizer, bit timer, shift register, `byte_valid`, `frame_err`), instantiated once inside `imem_loader`. The FSM, word assembler and checksum live in the top.

## Test plan
All scenarios use CLK_FREQ=1_600_000 and BAUD=100_000, so CLKS_PER_BIT=16.
1. Send bytes `00 A5 00 02 20 01 00 05 00 22 08 20 2E`.
   - The leading `00` is ignored.
   - Expect writes addr0=`0x20010005` and addr1=`0x00220820`.
   - Then `load_done`=1, `cpu_reset`=0, `load_error`=0.
2. Send the same frame with checksum `2F`.
   - Both words are written.
   - Then `load_error`=1, `cpu_reset`=1, `load_done`=0.
3. Send `A5 00 00`: ERROR directly after LEN_LO, with no `imem_we` pulse.
4. Send a frame whose 3rd data byte has stop bit=0: ERROR, with no write for that word.
5. Pull `reset_n` low after 5 data bytes, then send the frame from scenario 1.
   - Expect reset values immediately.
   - After the resend, writes start again at addr 0 and end in DONE.
6. After scenario 1, send `A5`: `cpu_reset`=1 and `load_busy`=1 one cycle after `byte_valid`.
   - A 1-cycle low glitch on `uart_rx` produces no byte.
